// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter in front of a single UART transmitter: grants one requester's byte,
// pulses tx_enable, then stays busy for the whole frame time plus GUARD idle cycles.
module uart_tx_arbiter #(
    parameter real FREQ     = 1e9,
    parameter real BAUD     = 115200.0,
    parameter real STOP_BIT = 1.0,
    parameter int  N        = 4,
    parameter int  GUARD    = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic [7:0]     tx_data,
    output logic           tx_enable,
    output logic           tx_done,
    output logic           busy,
    output logic [2:0]     grant_id
);
    localparam int BIT_CYCLES   = $rtoi(FREQ / BAUD);
    localparam int FRAME_CYCLES = $rtoi($ceil((9.0 + STOP_BIT) * real'(BIT_CYCLES))) + GUARD;
    localparam int CW           = $clog2(FRAME_CYCLES + 1);
    localparam bit PARAMS_OK    = (STOP_BIT == 1.0 || STOP_BIT == 1.5 || STOP_BIT == 2.0)
                                  && N >= 2 && N <= 8;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] counter, counter_n;
    logic [N-1:0]  ready_n;
    logic [7:0]    data_n;
    logic          enable_n, done_n;
    logic [2:0]    gid_n;

    logic [7:0]    vld8;
    logic [63:0]   dat64;
    logic          found;
    logic [2:0]    win;
    logic [3:0]    cand;
    logic [7:0]    win_data;

    always @(posedge clk) begin
        assert (PARAMS_OK) else $error("uart_tx_arbiter: STOP_BIT must be 1, 1.5 or 2 and N in 2..8");
    end

    // Search starts one past the last winner and wraps, so every requester gets a turn.
    always_comb begin
        vld8  = 8'(req_valid);
        dat64 = 64'(req_data);
        found = 1'b0;
        win   = grant_id;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = 4'(grant_id) + 4'(k);
            if (cand >= 4'(N))
                cand = cand - 4'(N);
            if (!found && vld8[cand[2:0]]) begin
                found = 1'b1;
                win   = cand[2:0];
            end
        end
        win_data = dat64[{win, 3'b000} +: 8];
    end

    always_comb begin
        state_n   = state;
        counter_n = counter;
        ready_n   = '0;
        enable_n  = 1'b0;
        done_n    = 1'b0;
        data_n    = tx_data;
        gid_n     = grant_id;
        case (state)
            IDLE: begin
                if (found) begin
                    data_n   = win_data;
                    enable_n = 1'b1;
                    ready_n  = {{(N-1){1'b0}}, 1'b1} << win;
                    gid_n    = win;
                    state_n  = LOAD;
                end
            end
            LOAD: begin
                counter_n = CW'(FRAME_CYCLES - 1);
                state_n   = WAIT;
            end
            WAIT: begin
                if (counter == '0) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    counter_n = counter - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            req_ready <= '0;
            tx_data   <= '0;
            tx_enable <= 1'b0;
            tx_done   <= 1'b0;
            busy      <= 1'b0;
            grant_id  <= 3'(N - 1);
        end else begin
            state     <= state_n;
            counter   <= counter_n;
            req_ready <= ready_n;
            tx_data   <= data_n;
            tx_enable <= enable_n;
            tx_done   <= done_n;
            busy      <= (state_n != IDLE);
            grant_id  <= gid_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter at FREQ=8, BAUD=1, GUARD=2 (frame 82 cycles), plus 1.5/2 stop-bit variants.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int F = 82;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_enable, tx_done, busy;
    logic [2:0]  grant_id;

    logic [3:0]  v_valid;
    logic [31:0] v_data;
    logic [3:0]  a_ready, b_ready;
    logic [7:0]  a_data, b_data;
    logic        a_en, a_done, a_busy, b_en, b_done, b_busy;
    logic [2:0]  a_gid, b_gid;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.FREQ(8.0), .BAUD(1.0), .STOP_BIT(1.0), .N(4), .GUARD(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_data(tx_data), .tx_enable(tx_enable),
        .tx_done(tx_done), .busy(busy), .grant_id(grant_id));

    uart_tx_arbiter #(.FREQ(8.0), .BAUD(1.0), .STOP_BIT(1.5), .N(4), .GUARD(2)) u_s15 (
        .clk(clk), .reset(reset), .req_valid(v_valid), .req_data(v_data),
        .req_ready(a_ready), .tx_data(a_data), .tx_enable(a_en),
        .tx_done(a_done), .busy(a_busy), .grant_id(a_gid));

    uart_tx_arbiter #(.FREQ(8.0), .BAUD(1.0), .STOP_BIT(2.0), .N(4), .GUARD(2)) u_s20 (
        .clk(clk), .reset(reset), .req_valid(v_valid), .req_data(v_data),
        .req_ready(b_ready), .tx_data(b_data), .tx_enable(b_en),
        .tx_done(b_done), .busy(b_busy), .grant_id(b_gid));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a grant may happen at edge e only once e >= next_sample; each grant
    // then blocks the arbiter for F+2 edges and produces tx_done at edge grant+F+1.
    int         cyc, next_sample, done_at, grant_edge, last;
    logic [7:0] m_data;

    task automatic model_reset();
        cyc = 0; next_sample = 0; done_at = -1; grant_edge = -1; last = N - 1; m_data = 8'h00;
    endtask

    task automatic step(input string name, output logic [3:0] exp_ready);
        logic [3:0] er;
        logic       en, dn, bz;
        logic [1:0] idx;
        int         w;
        er = '0; en = 1'b0; w = -1;
        if (cyc >= next_sample && req_valid != 4'b0) begin
            for (int k = 1; k <= N; k++) begin
                idx = 2'((last + k) % N);
                if (w < 0 && req_valid[idx]) w = int'(idx);
            end
            er = 4'(1) << w;
            en = 1'b1;
            last = w;
            m_data = req_data[8*w +: 8];
            grant_edge = cyc;
            done_at = cyc + F + 1;
            next_sample = cyc + F + 2;
        end
        dn = (cyc == done_at);
        bz = (grant_edge >= 0 && cyc >= grant_edge && cyc < done_at);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check(name, {req_ready, tx_enable, tx_done, busy, grant_id, tx_data},
              {er, en, dn, bz, 3'(last), m_data});
        exp_ready = er;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [2:0]  exp_gid;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t       tbl[8];
    logic [3:0] er, prev_ready;
    int         k, k15, k20;
    logic       seen, any_done;
    int         en_cyc[$];
    int         en_gid[$];

    initial begin
        tbl[0] = '{4'b0001, 32'h0000_0055, 4'b0001, 3'd0, 8'h55};
        tbl[1] = '{4'b0100, 32'h3322_1100, 4'b0100, 3'd2, 8'h22};
        tbl[2] = '{4'b1011, 32'hA3A2_A1A0, 4'b1000, 3'd3, 8'hA3};
        tbl[3] = '{4'b1011, 32'hA3A2_A1A0, 4'b0001, 3'd0, 8'hA0};
        tbl[4] = '{4'b1011, 32'hA3A2_A1A0, 4'b0010, 3'd1, 8'hA1};
        tbl[5] = '{4'b0110, 32'h0F0E_0D0C, 4'b0100, 3'd2, 8'h0E};
        tbl[6] = '{4'b0010, 32'h0000_BB00, 4'b0010, 3'd1, 8'hBB};
        tbl[7] = '{4'b1000, 32'hCC00_0000, 4'b1000, 3'd3, 8'hCC};

        reset = 1'b1; req_valid = '0; req_data = '0; v_valid = '0; v_data = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {req_ready, tx_enable, tx_done, busy, grant_id, tx_data},
              {4'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'h00});
        reset = 1'b0;

        // Table vectors, each applied with the arbiter idle.
        for (int i = 0; i < 8; i++) begin
            req_valid = tbl[i].valid;
            req_data  = tbl[i].data;
            @(posedge clk); @(negedge clk);
            check("vec_grant", {req_ready, tx_enable, grant_id, tx_data},
                  {tbl[i].exp_ready, 1'b1, tbl[i].exp_gid, tbl[i].exp_data});
            req_valid = '0;
            k = 0; seen = 1'b0;
            while (k < 200 && !seen) begin
                @(negedge clk);
                k++;
                if (k == 1)
                    check("vec_pulse_end", {req_ready, tx_enable, busy}, {4'b0, 1'b0, 1'b1});
                seen = tx_done;
            end
            check("vec_done_latency", 64'(k), 64'(F + 1));
            check("vec_data_hold", {busy, tx_data}, {1'b0, tbl[i].exp_data});
        end

        // Continuous requests from everyone: fair order and fixed spacing.
        do_reset();
        req_valid = 4'b1111; req_data = 32'hA3A2_A1A0;
        for (int i = 0; i < 340; i++) begin
            step("cont_step", er);
            if (tx_enable) begin
                en_cyc.push_back(cyc);
                en_gid.push_back(int'(grant_id));
            end
        end
        check("cont_grant_count", 64'(en_cyc.size()), 64'(5));
        if (en_cyc.size() >= 5) begin
            for (int i = 0; i < 4; i++)
                check("cont_spacing", 64'(en_cyc[i+1] - en_cyc[i]), 64'(F + 2));
            check("cont_order", {3'(en_gid[0]), 3'(en_gid[1]), 3'(en_gid[2]), 3'(en_gid[3]), 3'(en_gid[4])},
                  {3'd0, 3'd1, 3'd2, 3'd3, 3'd0});
        end

        // Reset 10 cycles into WAIT: frame abandoned, no tx_done, requester 0 priority restored.
        do_reset();
        req_valid = 4'b0001; req_data = 32'h0000_0077;
        step("rst_grant", er);
        req_valid = '0;
        for (int i = 0; i < 11; i++) step("rst_wait", er);
        reset = 1'b1;
        #1;
        check("rst_async", {req_ready, tx_enable, tx_done, busy, tx_data}, {4'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        any_done = 1'b0;
        for (int i = 0; i < F + 10; i++) begin
            @(negedge clk);
            any_done = any_done | tx_done | busy;
        end
        check("rst_no_done", 64'(any_done), 64'(0));
        reset = 1'b0;
        model_reset();
        req_valid = 4'b0100; req_data = 32'h0099_0000;
        step("rst_regrant", er);
        check("rst_regrant_id", {tx_enable, grant_id}, {1'b1, 3'd2});

        // req_ready drops the moment reset rises.
        do_reset();
        req_valid = 4'b0010; req_data = 32'h0000_1100;
        @(posedge clk); #1;
        check("ready_high", 64'(req_ready), 64'(4'b0010));
        reset = 1'b1; #1;
        check("ready_async_drop", {req_ready, tx_enable}, {4'b0, 1'b0});
        @(negedge clk);
        do_reset();

        // Randomized traffic against the model, including withdrawn requests and back-to-back bytes.
        prev_ready = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int j = 0; j < N; j++) begin
                if (prev_ready[j]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        req_valid[j] = 1'b1;
                        req_data[8*j +: 8] = 8'($urandom);
                    end else begin
                        req_valid[j] = 1'b0;
                    end
                end else if (!req_valid[j]) begin
                    if ($urandom_range(0, 9) == 0) begin
                        req_valid[j] = 1'b1;
                        req_data[8*j +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 199) == 0) begin
                    req_valid[j] = 1'b0;
                end
            end
            step("rand", er);
            prev_ready = er;
        end
        req_valid = '0;

        // Stop-bit variants: 1.5 -> 86-cycle frame, 2 -> 90-cycle frame.
        v_valid = 4'b0001; v_data = 32'h0000_0055;
        @(posedge clk); @(negedge clk);
        check("stop_var_enable", {a_en, b_en}, {1'b1, 1'b1});
        v_valid = '0;
        k = 0; k15 = 0; k20 = 0;
        while (k < 200 && (k15 == 0 || k20 == 0)) begin
            @(negedge clk);
            k++;
            if (a_done && k15 == 0) k15 = k;
            if (b_done && k20 == 0) k20 = k;
        end
        check("stop1p5_latency", 64'(k15), 64'(87));
        check("stop2_latency", 64'(k20), 64'(91));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter FREQ, default 1e9: clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200: line rate in bit/s.
REQ-003 SHALL have parameter STOP_BIT, default 1: legal values 1, 1.5, 2 only; simulation assertion on any other value.
REQ-004 SHALL have parameter N, default 4: requester count, legal range 2..8.
REQ-005 SHALL have parameter GUARD, default 2: idle cycles added after each frame.
REQ-006 SHALL have port clk, input, 1 bit: single clock; every flop is on posedge clk.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port req_valid, input, N bits: requester i has a byte pending.
REQ-009 SHALL have port req_data, input, 8*N bits: byte i is bits [8i+7:8i]; stable while req_valid[i]=1.
REQ-010 SHALL have port req_ready, output, N bits: one-cycle grant/accept pulse to requester i.
REQ-011 SHALL have port tx_data, output, 8 bits: byte presented to the transmitter data input.
REQ-012 SHALL have port tx_enable, output, 1 bit: one-cycle start pulse to the transmitter enable input.
REQ-013 SHALL have port tx_done, output, 1 bit: one-cycle pulse when the frame time has elapsed.
REQ-014 SHALL have port busy, output, 1 bit: high in LOAD and WAIT.
REQ-015 SHALL have port grant_id, output, 3 bits: index of the last granted requester.

Function
REQ-016 SHALL compute BIT_CYCLES = FREQ/BAUD (integer) and FRAME_CYCLES = ceil((9+STOP_BIT)*BIT_CYCLES) + GUARD.
REQ-017 SHALL implement states IDLE, LOAD and WAIT, encoded in a registered state variable.
REQ-018 IDLE with any sampled req_valid bit set SHALL, at the next edge: select winner g, tx_data<=req_data[g], tx_enable<=1, req_ready[g]<=1, grant_id<=g, state<=LOAD.
REQ-019 IDLE with req_valid=0 SHALL hold all outputs at their idle values: tx_enable=0, req_ready=0, tx_done=0, busy=0.
REQ-020 LOAD SHALL last exactly one cycle, then: tx_enable<=0, req_ready<=0, counter<=FRAME_CYCLES-1, state<=WAIT.
REQ-021 WAIT SHALL decrement the counter by 1 per cycle.
REQ-022 WAIT with counter==0 SHALL pulse tx_done for one cycle and set state<=IDLE.
REQ-023 SHALL ignore req_valid in LOAD and WAIT.
REQ-024 tx_data SHALL hold its value until the next grant.
REQ-025 Arbitration SHALL be round-robin: search starts at (grant_id+1) mod N and takes the first set req_valid bit ascending, with wrap-around.
REQ-026 SHALL leave the round-robin pointer unchanged when no grant occurs.
REQ-027 At most one req_ready bit SHALL be high in any cycle; req_ready and tx_enable SHALL be asserted in the same cycle.
REQ-028 Under continuous requests, rising edges of tx_enable SHALL be spaced exactly FRAME_CYCLES+2 cycles.
REQ-029 A requester that drops req_valid before its req_ready pulse SHALL lose no state and SHALL NOT be granted.
REQ-030 A requester keeping req_valid=1 after its req_ready pulse SHALL be treated as presenting a new byte.
REQ-031 All outputs SHALL be registered; there is no combinational path from req_* to any output.

Reset
REQ-032 While reset=1, outputs SHALL be forced immediately: req_ready=0, tx_enable=0, tx_done=0, busy=0, tx_data=0.
REQ-033 While reset=1, state=IDLE, counter=0 and grant_id=N-1, so requester 0 has top priority after reset.
REQ-034 Reset mid-LOAD or mid-WAIT SHALL abandon the frame count without emitting tx_done.
REQ-035 An asserted req_ready SHALL drop asynchronously on reset.
REQ-036 The transmitter is not reset by this block; the integrator holds reset >= FRAME_CYCLES when a frame may be in flight.

Verification (FREQ=8, BAUD=1, STOP_BIT=1, N=4, GUARD=2 -> FRAME_CYCLES=82)
REQ-037 Single request: req_valid=0001, byte 0x55 -> one cycle later req_ready=0001, tx_enable=1, tx_data=0x55, grant_id=0; tx_done exactly 83 cycles after the tx_enable cycle.
REQ-038 All four requesting continuously with bytes 0xA0..0xA3 -> grant order 0,1,2,3,0 with tx_enable spaced 84 cycles; each req_ready is a single-cycle pulse.
REQ-039 After a grant to requester 2, req_valid=1011 -> next grant to 3, then 0, then 1.
REQ-040 Requests raised during WAIT -> no req_ready or tx_enable until the cycle after tx_done.
REQ-041 Reset asserted 10 cycles into WAIT -> busy=0 at once, no tx_done; after release with req_valid=0100 -> grant to 2 within 1 cycle.
REQ-042 STOP_BIT=1.5 -> FRAME_CYCLES=86; STOP_BIT=2 -> FRAME_CYCLES=90; STOP_BIT=3 -> assertion fires.
